sequence_checker: RTL and testbench
===================================

Name: sequence_checker

Overview:
- Sits directly downstream of the seven-segment sequence display stage. It consumes that stage's player selection (sequence_out) and next-button, and compares the entered nibbles against the expected 16-bit sequence.
- Tracks per-entry timeout and strikes, and reports solved/failed status to the game controller and strike display.
- Arms on the same display phase code that starts the sequence preview.

Parameters:
- ARM_CODE, 8'h10, display value that arms the checker.
- SHOW_SEC, 2, one_sec pulses to wait while the sequence is previewed.
- ENTRY_SEC, 10, seconds allowed per nibble entry (1..15).
- MAX_STRIKES, 3, strikes that cause failure (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- display  in  8  game phase code.
- sequence_in  in  16  expected sequence, four active-low one-hot nibbles; nibble 0 = [3:0].
- sequence_out  in  4  player's current selection from the display stage.
- button_next  in  1  level from the debounced button; edge-detected internally.
- one_sec  in  1  one-cycle pulse once per second.
- solved  out  1  high and held once the sequence is matched.
- failed  out  1  high and held once strikes reach MAX_STRIKES.
- strike  out  1  one-cycle pulse per failed attempt.
- strike_count  out  2  strikes so far.
- entry_idx  out  2  nibble currently being entered.
- entry_timer  out  4  seconds remaining for the current entry.
- captured  out  16  nibbles entered so far in this attempt.

Behaviour:
- Reset (asynchronous, active-high): state IDLE.
  - solved, failed, strike = 0.
  - strike_count, entry_idx = 0.
  - entry_timer = ENTRY_SEC.
  - captured = 16'hFFFF.
  - Expected register = 16'hFFFF; match flag = 1; button edge register = 0.
- Next-button edge: edge = button_next & ~btn_q. btn_q registers button_next every cycle in every state.
- IDLE:
  - When display == ARM_CODE: latch sequence_in into the expected register, clear the second counter, go to SHOW.
  - sequence_in is not sampled again until the next arm.
- SHOW:
  - Each one_sec pulse increments the second counter.
  - When the counter == SHOW_SEC: go to COLLECT with entry_idx = 0, entry_timer = ENTRY_SEC, match = 1, captured = 16'hFFFF.
- COLLECT, on an edge:
  - Write sequence_out into captured[4*entry_idx +: 4].
  - match &= (sequence_out == expected nibble entry_idx).
  - Reload entry_timer = ENTRY_SEC.
  - If entry_idx == 3, go to JUDGE; else increment entry_idx.
- COLLECT, one_sec with no edge:
  - Decrement entry_timer.
  - If entry_timer was 1 (reaches 0): force match = 0 and go to JUDGE.
- Simultaneous edge and one_sec: the edge wins, the timer reloads, and the one_sec is ignored.
- JUDGE (one cycle):
  - If match: go to SOLVED.
  - Else: pulse strike for exactly this cycle and increment strike_count.
    - If the new count == MAX_STRIKES: go to FAILED.
    - Else: go to COLLECT with entry_idx = 0, entry_timer = ENTRY_SEC, match = 1, captured = 16'hFFFF. The expected sequence is retained.
- SOLVED: solved = 1. Absorbing until reset; all inputs ignored.
- FAILED: failed = 1. Absorbing until reset. strike_count holds MAX_STRIKES and never wraps.
- After arming, display changes are ignored.
- An edge in IDLE, SHOW, JUDGE, SOLVED or FAILED is discarded (not queued).
- Reset asserted in any state, including mid-JUDGE, returns to the reset values immediately; a strike pulse in progress is cut.
- solved and failed are never high together.

Test Plan:
- Correct entry: sequence_in = 16'h7BDE, display = 8'h10, two one_sec pulses, then enter E, D, B, 7 with next-edges → solved = 1 one cycle after the 4th edge; strike never pulses; captured = 16'h7BDE.
- Wrong entry: enter E, E, B, 7 → one strike pulse, strike_count = 1, entry_idx = 0, captured = 16'hFFFF. Re-entering correctly → solved = 1.
- Timeout: after arming, hold button_next low for 10 one_sec pulses → entry_timer steps 10..1 to 0; strike pulses; strike_count = 1; timer reloads to 10.
- Three failures: three wrong attempts → failed = 1, strike_count = 3, exactly 3 strike pulses. Further edges leave all outputs unchanged.
- Held button and simultaneous events: hold button_next high for 20 cycles → only one nibble captured. A next-edge in the same cycle as one_sec → capture occurs, entry_timer = 10.
- Mid-operation reset: assert reset while entry_idx = 2 → all outputs return to reset values the same cycle (asynchronously). display must return to 8'h10 to re-arm.

Source files
------------

// File: rtl/sequence_checker_if.sv
// Handshake bundle between the sequence display stage, the checker and the game controller.
// The master side drives the player inputs; the slave side is the checker itself.
interface sequence_checker_if;
  logic [7:0]  display;
  logic [15:0] sequence_in;
  logic [3:0]  sequence_out;
  logic        button_next;
  logic        one_sec;
  logic        solved;
  logic        failed;
  logic        strike;
  logic [1:0]  strike_count;
  logic [1:0]  entry_idx;
  logic [3:0]  entry_timer;
  logic [15:0] captured;

  modport master (
    output display, sequence_in, sequence_out, button_next, one_sec,
    input  solved, failed, strike, strike_count, entry_idx, entry_timer, captured
  );

  modport slave (
    input  display, sequence_in, sequence_out, button_next, one_sec,
    output solved, failed, strike, strike_count, entry_idx, entry_timer, captured
  );
endinterface

// File: rtl/sequence_checker.sv
// Compares the player's four entered nibbles against the armed sequence, with
// per-entry timeout, strike tracking and absorbing solved/failed outcomes.
module sequence_checker #(
  parameter logic [7:0] ARM_CODE    = 8'h10,
  parameter int         SHOW_SEC    = 2,
  parameter int         ENTRY_SEC   = 10,
  parameter int         MAX_STRIKES = 3
) (
  input logic               clk,
  input logic               reset,
  sequence_checker_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW    = 3'd1,
    COLLECT = 3'd2,
    JUDGE   = 3'd3,
    SOLVED  = 3'd4,
    FAILED  = 3'd5
  } state_t;

  localparam logic [7:0]  SHOW_SEC_C    = 8'(SHOW_SEC);
  localparam logic [3:0]  ENTRY_SEC_C   = 4'(ENTRY_SEC);
  localparam logic [1:0]  MAX_STRIKES_C = 2'(MAX_STRIKES);
  localparam logic [15:0] BLANK_C       = 16'hFFFF;

  state_t      state_q;
  logic        btn_q;
  logic [15:0] expected_q;
  logic [15:0] captured_q;
  logic        match_q;
  logic [7:0]  sec_q;
  logic [1:0]  strike_count_q;
  logic [1:0]  entry_idx_q;
  logic [3:0]  entry_timer_q;
  logic        solved_q;
  logic        failed_q;
  logic        strike_q;

  logic        edge_s;
  logic [3:0]  exp_nib_s;
  logic        match_nib_s;
  logic [1:0]  strike_inc_s;

  assign edge_s       = bus.button_next & ~btn_q;
  assign exp_nib_s    = expected_q[4*entry_idx_q +: 4];
  assign match_nib_s  = match_q & (bus.sequence_out == exp_nib_s);
  assign strike_inc_s = strike_count_q + 2'd1;

  // Strike is raised on the transition into JUDGE so the pulse covers exactly the JUDGE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      btn_q          <= 1'b0;
      expected_q     <= BLANK_C;
      captured_q     <= BLANK_C;
      match_q        <= 1'b1;
      sec_q          <= 8'd0;
      strike_count_q <= 2'd0;
      entry_idx_q    <= 2'd0;
      entry_timer_q  <= ENTRY_SEC_C;
      solved_q       <= 1'b0;
      failed_q       <= 1'b0;
      strike_q       <= 1'b0;
    end else begin
      btn_q    <= bus.button_next;
      strike_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.display == ARM_CODE) begin
            expected_q <= bus.sequence_in;
            sec_q      <= 8'd0;
            state_q    <= SHOW;
          end
        end
        SHOW: begin
          if (sec_q == SHOW_SEC_C) begin
            state_q       <= COLLECT;
            entry_idx_q   <= 2'd0;
            entry_timer_q <= ENTRY_SEC_C;
            match_q       <= 1'b1;
            captured_q    <= BLANK_C;
          end else if (bus.one_sec) begin
            sec_q <= sec_q + 8'd1;
          end
        end
        COLLECT: begin
          // An edge takes priority over a coincident one_sec pulse.
          if (edge_s) begin
            captured_q[4*entry_idx_q +: 4] <= bus.sequence_out;
            match_q       <= match_nib_s;
            entry_timer_q <= ENTRY_SEC_C;
            if (entry_idx_q == 2'd3) begin
              state_q  <= JUDGE;
              strike_q <= ~match_nib_s;
            end else begin
              entry_idx_q <= entry_idx_q + 2'd1;
            end
          end else if (bus.one_sec) begin
            entry_timer_q <= entry_timer_q - 4'd1;
            if (entry_timer_q == 4'd1) begin
              match_q  <= 1'b0;
              strike_q <= 1'b1;
              state_q  <= JUDGE;
            end
          end
        end
        JUDGE: begin
          if (match_q) begin
            state_q  <= SOLVED;
            solved_q <= 1'b1;
          end else begin
            strike_count_q <= strike_inc_s;
            if (strike_inc_s == MAX_STRIKES_C) begin
              state_q  <= FAILED;
              failed_q <= 1'b1;
            end else begin
              state_q       <= COLLECT;
              entry_idx_q   <= 2'd0;
              entry_timer_q <= ENTRY_SEC_C;
              match_q       <= 1'b1;
              captured_q    <= BLANK_C;
            end
          end
        end
        SOLVED: begin
          state_q <= SOLVED;
        end
        FAILED: begin
          state_q <= FAILED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.solved       = solved_q;
  assign bus.failed       = failed_q;
  assign bus.strike       = strike_q;
  assign bus.strike_count = strike_count_q;
  assign bus.entry_idx    = entry_idx_q;
  assign bus.entry_timer  = entry_timer_q;
  assign bus.captured     = captured_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: one task per scenario, inline comparisons.
module tb_sequence_checker;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   strike_pulses;

  sequence_checker_if bus ();

  sequence_checker #(
    .ARM_CODE   (8'h10),
    .SHOW_SEC   (2),
    .ENTRY_SEC  (10),
    .MAX_STRIKES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.strike === 1'b1) strike_pulses = strike_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.display     = 8'h00;
    bus.sequence_in = 16'h0000;
    bus.sequence_out = 4'hF;
    bus.button_next = 1'b0;
    bus.one_sec     = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    strike_pulses = 0;
  endtask

  task automatic arm(input logic [15:0] seq);
    bus.sequence_in = seq;
    bus.display = 8'h10;
    cyc();
    bus.display = 8'h00;
    bus.sequence_in = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      bus.one_sec = 1'b1;
      cyc();
      bus.one_sec = 1'b0;
      cyc();
    end
    cyc();
  endtask

  task automatic press(input logic [3:0] nib);
    bus.sequence_out = nib;
    bus.button_next = 1'b1;
    cyc();
    bus.button_next = 1'b0;
    cyc();
  endtask

  task automatic wrong_attempt();
    press(4'hE);
    press(4'hE);
    press(4'hB);
    press(4'h7);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.solved !== 1'b0) begin failures++; $display("FAIL reset_solved got=%b exp=0", bus.solved); end
    checks++; if (bus.failed !== 1'b0) begin failures++; $display("FAIL reset_failed got=%b exp=0", bus.failed); end
    checks++; if (bus.strike !== 1'b0) begin failures++; $display("FAIL reset_strike got=%b exp=0", bus.strike); end
    checks++; if (bus.strike_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.strike_count); end
    checks++; if (bus.entry_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.entry_idx); end
    checks++; if (bus.entry_timer !== 4'd10) begin failures++; $display("FAIL reset_timer got=%0d exp=10", bus.entry_timer); end
    checks++; if (bus.captured !== 16'hFFFF) begin failures++; $display("FAIL reset_captured got=%h exp=ffff", bus.captured); end
  endtask

  task automatic test_correct();
    do_reset();
    arm(16'h7BDE);
    checks++; if (bus.entry_timer !== 4'd10) begin failures++; $display("FAIL correct_timer0 got=%0d exp=10", bus.entry_timer); end
    press(4'hE);
    checks++; if (bus.entry_idx !== 2'd1) begin failures++; $display("FAIL correct_idx1 got=%0d exp=1", bus.entry_idx); end
    checks++; if (bus.captured !== 16'hFFFE) begin failures++; $display("FAIL correct_cap1 got=%h exp=fffe", bus.captured); end
    press(4'hD);
    press(4'hB);
    bus.sequence_out = 4'h7;
    bus.button_next = 1'b1;
    cyc();
    checks++; if (bus.solved !== 1'b0) begin failures++; $display("FAIL correct_judge_solved got=%b exp=0", bus.solved); end
    bus.button_next = 1'b0;
    cyc();
    checks++; if (bus.solved !== 1'b1) begin failures++; $display("FAIL correct_solved got=%b exp=1", bus.solved); end
    checks++; if (bus.failed !== 1'b0) begin failures++; $display("FAIL correct_failed got=%b exp=0", bus.failed); end
    checks++; if (bus.captured !== 16'h7BDE) begin failures++; $display("FAIL correct_captured got=%h exp=7bde", bus.captured); end
    checks++; if (strike_pulses !== 0) begin failures++; $display("FAIL correct_strikes got=%0d exp=0", strike_pulses); end
    press(4'h0);
    bus.one_sec = 1'b1;
    cyc();
    bus.one_sec = 1'b0;
    cyc();
    checks++; if (bus.captured !== 16'h7BDE) begin failures++; $display("FAIL solved_absorb_cap got=%h exp=7bde", bus.captured); end
    checks++; if (bus.solved !== 1'b1) begin failures++; $display("FAIL solved_absorb got=%b exp=1", bus.solved); end
  endtask

  task automatic test_wrong();
    do_reset();
    arm(16'h7BDE);
    wrong_attempt();
    checks++; if (strike_pulses !== 1) begin failures++; $display("FAIL wrong_pulses got=%0d exp=1", strike_pulses); end
    checks++; if (bus.strike_count !== 2'd1) begin failures++; $display("FAIL wrong_count got=%0d exp=1", bus.strike_count); end
    checks++; if (bus.entry_idx !== 2'd0) begin failures++; $display("FAIL wrong_idx got=%0d exp=0", bus.entry_idx); end
    checks++; if (bus.captured !== 16'hFFFF) begin failures++; $display("FAIL wrong_captured got=%h exp=ffff", bus.captured); end
    checks++; if (bus.solved !== 1'b0) begin failures++; $display("FAIL wrong_solved got=%b exp=0", bus.solved); end
    press(4'hE);
    press(4'hD);
    press(4'hB);
    press(4'h7);
    checks++; if (bus.solved !== 1'b1) begin failures++; $display("FAIL retry_solved got=%b exp=1", bus.solved); end
    checks++; if (bus.strike_count !== 2'd1) begin failures++; $display("FAIL retry_count got=%0d exp=1", bus.strike_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    arm(16'h7BDE);
    for (int i = 0; i < 10; i++) begin
      bus.one_sec = 1'b1;
      cyc();
      bus.one_sec = 1'b0;
      checks++; if (bus.entry_timer !== 4'(9 - i)) begin failures++; $display("FAIL timeout_timer step=%0d got=%0d exp=%0d", i, bus.entry_timer, 9 - i); end
    end
    checks++; if (bus.strike !== 1'b1) begin failures++; $display("FAIL timeout_strike got=%b exp=1", bus.strike); end
    cyc();
    checks++; if (bus.strike !== 1'b0) begin failures++; $display("FAIL timeout_strike_end got=%b exp=0", bus.strike); end
    checks++; if (bus.strike_count !== 2'd1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", bus.strike_count); end
    checks++; if (bus.entry_timer !== 4'd10) begin failures++; $display("FAIL timeout_reload got=%0d exp=10", bus.entry_timer); end
    checks++; if (strike_pulses !== 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", strike_pulses); end
  endtask

  task automatic test_three_fail();
    do_reset();
    arm(16'h7BDE);
    wrong_attempt();
    wrong_attempt();
    wrong_attempt();
    checks++; if (bus.failed !== 1'b1) begin failures++; $display("FAIL three_failed got=%b exp=1", bus.failed); end
    checks++; if (bus.solved !== 1'b0) begin failures++; $display("FAIL three_solved got=%b exp=0", bus.solved); end
    checks++; if (bus.strike_count !== 2'd3) begin failures++; $display("FAIL three_count got=%0d exp=3", bus.strike_count); end
    checks++; if (strike_pulses !== 3) begin failures++; $display("FAIL three_pulses got=%0d exp=3", strike_pulses); end
    checks++; if (bus.captured !== 16'h7BEE) begin failures++; $display("FAIL three_captured got=%h exp=7bee", bus.captured); end
    press(4'hE);
    press(4'hD);
    bus.one_sec = 1'b1;
    cyc();
    bus.one_sec = 1'b0;
    cyc();
    checks++; if (bus.captured !== 16'h7BEE) begin failures++; $display("FAIL failed_absorb_cap got=%h exp=7bee", bus.captured); end
    checks++; if (bus.strike_count !== 2'd3) begin failures++; $display("FAIL failed_absorb_count got=%0d exp=3", bus.strike_count); end
    checks++; if (bus.entry_timer !== 4'd10) begin failures++; $display("FAIL failed_absorb_timer got=%0d exp=10", bus.entry_timer); end
    checks++; if (strike_pulses !== 3) begin failures++; $display("FAIL failed_absorb_pulses got=%0d exp=3", strike_pulses); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    arm(16'h7BDE);
    bus.sequence_out = 4'hE;
    bus.button_next = 1'b1;
    repeat (20) cyc();
    bus.button_next = 1'b0;
    cyc();
    checks++; if (bus.entry_idx !== 2'd1) begin failures++; $display("FAIL held_idx got=%0d exp=1", bus.entry_idx); end
    checks++; if (bus.captured !== 16'hFFFE) begin failures++; $display("FAIL held_captured got=%h exp=fffe", bus.captured); end
    bus.one_sec = 1'b1;
    cyc();
    bus.one_sec = 1'b0;
    cyc();
    checks++; if (bus.entry_timer !== 4'd9) begin failures++; $display("FAIL simul_pre_timer got=%0d exp=9", bus.entry_timer); end
    bus.sequence_out = 4'hD;
    bus.button_next = 1'b1;
    bus.one_sec = 1'b1;
    cyc();
    bus.button_next = 1'b0;
    bus.one_sec = 1'b0;
    checks++; if (bus.entry_timer !== 4'd10) begin failures++; $display("FAIL simul_timer got=%0d exp=10", bus.entry_timer); end
    checks++; if (bus.captured !== 16'hFFDE) begin failures++; $display("FAIL simul_captured got=%h exp=ffde", bus.captured); end
    checks++; if (bus.entry_idx !== 2'd2) begin failures++; $display("FAIL simul_idx got=%0d exp=2", bus.entry_idx); end
    cyc();
  endtask

  task automatic test_mid_reset();
    // Continues from test_back_to_back with entry_idx = 2.
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.entry_idx !== 2'd0) begin failures++; $display("FAIL midrst_idx got=%0d exp=0", bus.entry_idx); end
    checks++; if (bus.captured !== 16'hFFFF) begin failures++; $display("FAIL midrst_captured got=%h exp=ffff", bus.captured); end
    checks++; if (bus.entry_timer !== 4'd10) begin failures++; $display("FAIL midrst_timer got=%0d exp=10", bus.entry_timer); end
    cyc();
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      bus.one_sec = 1'b1;
      cyc();
      bus.one_sec = 1'b0;
      cyc();
    end
    press(4'hE);
    checks++; if (bus.entry_idx !== 2'd0) begin failures++; $display("FAIL unarmed_idx got=%0d exp=0", bus.entry_idx); end
    checks++; if (bus.captured !== 16'hFFFF) begin failures++; $display("FAIL unarmed_captured got=%h exp=ffff", bus.captured); end
    arm(16'h7BDE);
    press(4'hE);
    checks++; if (bus.entry_idx !== 2'd1) begin failures++; $display("FAIL rearm_idx got=%0d exp=1", bus.entry_idx); end
    // Reset during a JUDGE strike cuts the pulse immediately.
    press(4'hE);
    press(4'hB);
    bus.sequence_out = 4'h7;
    bus.button_next = 1'b1;
    cyc();
    bus.button_next = 1'b0;
    checks++; if (bus.strike !== 1'b1) begin failures++; $display("FAIL judge_strike got=%b exp=1", bus.strike); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.strike !== 1'b0) begin failures++; $display("FAIL judge_reset_strike got=%b exp=0", bus.strike); end
    checks++; if (bus.strike_count !== 2'd0) begin failures++; $display("FAIL judge_reset_count got=%0d exp=0", bus.strike_count); end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    strike_pulses = 0;
    reset = 1'b1;
    bus.display = 8'h00;
    bus.sequence_in = 16'h0000;
    bus.sequence_out = 4'hF;
    bus.button_next = 1'b0;
    bus.one_sec = 1'b0;
    test_reset();
    test_correct();
    test_wrong();
    test_timeout();
    test_three_fail();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
